sync_ram_req_adapter: RTL

- Front-end stage that sits directly upstream of the single-port synchronous block RAM and drives its read/write address, strobe and data pins.
- Converts a valid/ready request channel (read or byte-masked write) into RAM pin activity, at most one op per cycle.
- Absorbs the RAM's fixed 1-cycle read latency into an in-order response FIFO with valid/ready back-pressure.
- Used by cores and DMA masters to reach on-chip scratchpad RAM.

---
 rtl/sync_ram_req_adapter.sv | 118 +++++++++++
 1 files changed

// File: rtl/sync_ram_req_adapter.sv
// Valid/ready request front-end for a single-port synchronous RAM with an in-order response FIFO.
// Optional out-of-range address checking is enabled by defining SYNC_RAM_REQ_ADAPTER_ERR_EN.
module sync_ram_req_adapter #(
    parameter int BUS_ADDR_WIDTH = 32,
    parameter int RAM_ADDR_WIDTH = 12,
    parameter int DATA_WIDTH     = 32,
    parameter int RSP_DEPTH      = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_write,
    input  logic [BUS_ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH/8-1:0]   req_wstrb,
    input  logic [DATA_WIDTH-1:0]     req_wdata,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic                      rsp_write,
    output logic [DATA_WIDTH-1:0]     rsp_rdata,
    output logic                      rsp_err,
    output logic [RAM_ADDR_WIDTH-1:0] ram_raddr,
    output logic [RAM_ADDR_WIDTH-1:0] ram_waddr,
    output logic [DATA_WIDTH/8-1:0]   ram_wstrb,
    output logic [DATA_WIDTH-1:0]     ram_wdata,
    input  logic [DATA_WIDTH-1:0]     ram_rdata
);

    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH) + 1;

    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [CNT_W-1:0]      count;
    logic                  inflight;
    logic                  inflight_write;
    logic                  inflight_err;
    logic [CNT_W-1:0]      credits_used;
    logic                  req_fire;
    logic                  rsp_pop;
    logic                  addr_err;
    logic [DATA_WIDTH-1:0] push_data;

    logic [DATA_WIDTH-1:0] fifo_data  [RSP_DEPTH];
    logic                  fifo_write [RSP_DEPTH];
    logic                  fifo_err   [RSP_DEPTH];

    generate
        if (BUS_ADDR_WIDTH > RAM_ADDR_WIDTH) begin : g_upper
`ifdef SYNC_RAM_REQ_ADAPTER_ERR_EN
            assign addr_err = |req_addr[BUS_ADDR_WIDTH-1:RAM_ADDR_WIDTH];
`else
            logic unused_upper;
            assign unused_upper = ^req_addr[BUS_ADDR_WIDTH-1:RAM_ADDR_WIDTH];
            assign addr_err     = 1'b0;
`endif
        end else begin : g_no_upper
            assign addr_err = 1'b0;
        end
    endgenerate

    // A fired request reserves a FIFO slot one cycle before it is pushed, so
    // credits count the in-flight op as well as queued responses.
    assign credits_used = count + {{(CNT_W-1){1'b0}}, inflight};
    assign req_ready    = reset & (credits_used < CNT_W'(RSP_DEPTH));
    assign req_fire     = req_valid & req_ready;

    assign ram_raddr = req_addr[RAM_ADDR_WIDTH-1:0];
    assign ram_waddr = req_addr[RAM_ADDR_WIDTH-1:0];
    assign ram_wdata = req_wdata;
    assign ram_wstrb = (req_fire & req_write & ~addr_err) ? req_wstrb : '0;

    assign rsp_valid = (count != '0);
    assign rsp_pop   = rsp_valid & rsp_ready;
    assign rsp_write = rsp_valid & fifo_write[rd_ptr];
    assign rsp_err   = rsp_valid & fifo_err[rd_ptr];
    assign rsp_rdata = rsp_valid ? fifo_data[rd_ptr] : '0;

    assign push_data = (inflight_write | inflight_err) ? '0 : ram_rdata;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count          <= '0;
            inflight       <= 1'b0;
            inflight_write <= 1'b0;
            inflight_err   <= 1'b0;
        end else begin
            inflight <= req_fire;
            if (req_fire) begin
                inflight_write <= req_write;
                inflight_err   <= addr_err;
            end
            if (inflight) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rsp_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({inflight, rsp_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Response storage is not reset; entries are only observed once count covers them.
    always_ff @(posedge clock) begin
        if (inflight) begin
            fifo_data[wr_ptr]  <= push_data;
            fifo_write[wr_ptr] <= inflight_write;
            fifo_err[wr_ptr]   <= inflight_err;
        end
    end

endmodule
